hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter STALL_MAX, default 3: max legal consecutive stall cycles before error flag.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 id_rs1, id_rs2  input  5 each  source register addresses of instruction in ID (instr[19:15], instr[24:20]).
REQ-005 id_use_rs1, id_use_rs2  input  1 each  source actually read by ID instruction.
REQ-006 ex_rd, mem_rd, wb_rd  input  5 each  destination address held in ID_EX, EX_MEM, MEM_WB.
REQ-007 ex_rf_we, mem_rf_we, wb_rf_we  input  1 each  register-file write enable travelling with each stage.
REQ-008 pc_src  input  1  taken branch resolved in MEM (zero_reg & branch3).
REQ-009 pc_en, if_id_en  output  1 each  enables for PC and IF_ID.
REQ-010 if_id_flush, id_ex_bubble, ex_mem_flush  output  1 each  synchronous clear of IF_ID, ID_EX, EX_MEM.
REQ-011 stall  output  1  RAW stall active this cycle.
REQ-012 hz_state  output  2  FSM state: RUN=0, STALL=1, FLUSH=2.
REQ-013 hz_err  output  1  sticky stall-overrun flag.
REQ-014 stall_cnt, flush_cnt  output  32 each  performance counters (present only per REQ-030).

Function
REQ-015 Stage match SHALL be true when a stage rf_we=1, its rd!=0, and rd equals an ID source whose use bit is 1.
REQ-016 hazard SHALL be the OR of matches against EX, MEM and WB (no forwarding; WB write not visible to same-cycle read).
REQ-017 stall SHALL equal hazard & ~pc_src & (hz_state!=FLUSH), combinationally, same cycle.
REQ-018 pc_en and if_id_en SHALL equal ~stall.
REQ-019 id_ex_bubble SHALL equal stall | pc_src; if_id_flush and ex_mem_flush SHALL equal pc_src.
REQ-020 pc_src SHALL take priority over any hazard: flush outputs 1, stall 0, PC loads branch target.
REQ-021 FSM transitions: any state -> FLUSH when pc_src=1; RUN -> STALL when stall=1; STALL stays while stall=1; STALL -> RUN when stall=0; FLUSH -> RUN after exactly one cycle unless pc_src=1 again.
REQ-022 Consecutive-stall counter (3 bits, saturating at 7) SHALL increment each cycle stall=1 and clear on any cycle stall=0.
REQ-023 hz_err SHALL set on the edge where counter would exceed STALL_MAX and remain 1 until reset.
REQ-024 Back-to-back pc_src cycles SHALL each produce a full flush; FSM remains FLUSH.
REQ-025 Maximum legal RAW stall for one instruction is 3 cycles; default STALL_MAX matches.

Reset
REQ-026 rst_n=0 SHALL immediately force hz_state=RUN, stall counter=0, hz_err=0, perf counters=0, independent of clk.
REQ-027 During reset combinational outputs SHALL follow REQ-017..019 with hz_state=RUN.
REQ-028 Reset asserted mid-STALL or mid-FLUSH SHALL abandon the sequence; first cycle after release evaluates hazards fresh.
REQ-029 Reset release SHALL be sampled synchronously; no state change on the release edge other than normal update.

Configuration
REQ-030 Macro HAZARD_PERF_CNT_EN defined: stall_cnt increments each cycle stall=1, flush_cnt each cycle pc_src=1, both 32-bit wrapping 0xFFFFFFFF->0; undefined: ports and counters absent, all other behaviour identical.

Verification
REQ-031 ex_rd=5, ex_rf_we=1, id_rs1=5, use_rs1=1, hazard advancing EX->MEM->WB -> stall=1, pc_en=0, id_ex_bubble=1 for 3 cycles, hz_state STALL then RUN, hz_err=0.
REQ-032 ex_rd=0, ex_rf_we=1, id_rs1=0 -> stall=0, pc_en=1; also mem_rd=7 match with use_rs2=0 -> stall=0.
REQ-033 pc_src=1 with simultaneous EX match -> stall=0, if_id_flush=id_ex_bubble=ex_mem_flush=1, hz_state FLUSH next cycle, RUN cycle after.
REQ-034 Hazard held 4 cycles with STALL_MAX=3 -> hz_err=1 after 4th stall edge, stays 1 after hazard clears.
REQ-035 rst_n low mid-STALL (counter=2) -> hz_state=0, counter=0, hz_err=0 without clock edge.
REQ-036 With HAZARD_PERF_CNT_EN: 3 stall cycles then 2 pc_src cycles -> stall_cnt=3, flush_cnt=2; preload 0xFFFFFFFF then one stall -> stall_cnt=0.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if -- bundle between the pipeline datapath and the hazard controller.
//
// Optional macro: HAZARD_PERF_CNT_EN adds the stall_cnt / flush_cnt counters.
//
// Signals:
//   id_rs1, id_rs2          source register addresses of the instruction in ID
//   id_use_rs1, id_use_rs2  source actually read by the ID instruction
//   ex_rd, mem_rd, wb_rd    destination held in ID_EX, EX_MEM, MEM_WB
//   ex_rf_we, mem_rf_we,
//   wb_rf_we                register-file write enable travelling with each stage
//   pc_src                  taken branch resolved in MEM
//   pc_en, if_id_en         PC and IF_ID load enables
//   if_id_flush,
//   id_ex_bubble,
//   ex_mem_flush            synchronous clears of the pipeline registers
//   stall                   RAW stall active this cycle
//   hz_state                controller state (RUN=0, STALL=1, FLUSH=2)
//   hz_err                  sticky stall-overrun flag
//   stall_cnt, flush_cnt    performance counters (HAZARD_PERF_CNT_EN only)
//
// Modports: master = pipeline datapath, slave = hazard_ctrl.
interface hazard_ctrl_if;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic [4:0]  ex_rd;
    logic [4:0]  mem_rd;
    logic [4:0]  wb_rd;
    logic        ex_rf_we;
    logic        mem_rf_we;
    logic        wb_rf_we;
    logic        pc_src;
    logic        pc_en;
    logic        if_id_en;
    logic        if_id_flush;
    logic        id_ex_bubble;
    logic        ex_mem_flush;
    logic        stall;
    logic [1:0]  hz_state;
    logic        hz_err;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_rd, mem_rd, wb_rd, ex_rf_we, mem_rf_we, wb_rf_we, pc_src,
        input  pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_mem_flush,
        input  stall, hz_state, hz_err
`ifdef HAZARD_PERF_CNT_EN
        , input stall_cnt, flush_cnt
`endif
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_rd, mem_rd, wb_rd, ex_rf_we, mem_rf_we, wb_rf_we, pc_src,
        output pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_mem_flush,
        output stall, hz_state, hz_err
`ifdef HAZARD_PERF_CNT_EN
        , output stall_cnt, flush_cnt
`endif
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- RAW stall / branch flush controller for a 5-stage pipeline without forwarding.
//
// Optional macro: HAZARD_PERF_CNT_EN adds 32-bit wrapping stall and flush counters.
//
// Parameters:
//   STALL_MAX  longest legal run of consecutive stall cycles before hz_err sets
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   hz     hazard_ctrl_if.slave: ID sources, stage destinations, pc_src in;
//          enables, flushes, stall, hz_state, hz_err (and counters) out
module hazard_ctrl #(
    parameter int unsigned STALL_MAX = 3
) (
    input logic          clk,
    input logic          rst_n,
    hazard_ctrl_if.slave hz
);

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StStall = 2'd1,
        StFlush = 2'd2
    } hz_state_e;

    hz_state_e  state_q;
    logic [2:0] stall_run_q;  // consecutive stall cycles, saturating at 7
    logic       err_q;

    logic match_ex;
    logic match_mem;
    logic match_wb;
    logic hazard;
    logic stall;

    function automatic logic stage_match(input logic       we,
                                         input logic [4:0] rd,
                                         input logic [4:0] rs1,
                                         input logic [4:0] rs2,
                                         input logic       use1,
                                         input logic       use2);
        return we && (rd != 5'd0) && ((use1 && (rd == rs1)) || (use2 && (rd == rs2)));
    endfunction

    // WB is included: the register file write lands at the end of the cycle, so the
    // ID read in the same cycle would still see the stale value.
    always_comb begin
        match_ex  = stage_match(hz.ex_rf_we, hz.ex_rd, hz.id_rs1, hz.id_rs2,
                                hz.id_use_rs1, hz.id_use_rs2);
        match_mem = stage_match(hz.mem_rf_we, hz.mem_rd, hz.id_rs1, hz.id_rs2,
                                hz.id_use_rs1, hz.id_use_rs2);
        match_wb  = stage_match(hz.wb_rf_we, hz.wb_rd, hz.id_rs1, hz.id_rs2,
                                hz.id_use_rs1, hz.id_use_rs2);
        hazard    = match_ex | match_mem | match_wb;
        // A taken branch squashes the ID instruction, so its hazard is moot.
        stall     = hazard & ~hz.pc_src & (state_q != StFlush);
    end

    assign hz.stall        = stall;
    assign hz.pc_en        = ~stall;
    assign hz.if_id_en     = ~stall;
    assign hz.id_ex_bubble = stall | hz.pc_src;
    assign hz.if_id_flush  = hz.pc_src;
    assign hz.ex_mem_flush = hz.pc_src;
    assign hz.hz_state     = state_q;
    assign hz.hz_err       = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StRun;
            stall_run_q <= 3'd0;
            err_q       <= 1'b0;
        end else begin
            if (hz.pc_src) begin
                state_q <= StFlush;
            end else if (stall) begin
                state_q <= StStall;
            end else begin
                state_q <= StRun;
            end

            if (stall) begin
                if (stall_run_q != 3'd7) begin
                    stall_run_q <= stall_run_q + 3'd1;
                end
                // This edge would take the run past STALL_MAX.
                if (32'(stall_run_q) >= STALL_MAX) begin
                    err_q <= 1'b1;
                end
            end else begin
                stall_run_q <= 3'd0;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (stall) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (hz.pc_src) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;
`endif

endmodule
